seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Parametrised multiplexed seven-segment display driver for the board's 8-digit common-anode display. It captures a binary value on a load strobe and converts it to BCD with a sequential shift-and-add-3 engine. It then time-multiplexes up to 8 digits onto the shared cathode/anode pins at a programmable refresh rate, with per-digit decimal points and an overflow flag. It sits between counter/score logic and the top-level display pins.

## Interface
- `DIGITS`, 8: number of active digits, 1..8; anode bits at index ≥ DIGITS are held 1.
- `WIDTH`, 27: width of `number`, 4..32.
- `REFRESH_DIV`, 100000: clk cycles each digit is driven, ≥ 2. At 100 MHz this gives 1 ms per digit.
- `clk` in 1: system clock; all logic runs on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `number` in WIDTH: unsigned binary value; sampled only on an accepted `load`.
- `load` in 1: single-cycle strobe; accepted only when `busy`=0.
- `dp` in DIGITS: decimal-point enables, bit i = digit i; sampled live, not latched.
- `busy` out 1: conversion in progress.
- `overflow` out 1: last accepted value was ≥ 10^DIGITS.
- `cathode` out 8: active-low segments. Bit 7 = DP; bits 6:0 = G,F,E,D,C,B,A.
- `anode` out 8: active-low digit select, one-hot-low; bit 0 = rightmost digit.

## Operation
- Conversion FSM:
  - IDLE → SHIFT on `load`=1. On this transition, latch `number` into a shift register, clear the BCD register (4·DIGITS bits) and the overflow accumulator.
  - SHIFT:
    - Before each shift, add 3 to every BCD nibble ≥ 5.
    - Shift {BCD, binary} left by one.
    - OR the bit shifted out of the BCD MSB into the overflow accumulator.
    - Stay in SHIFT for exactly WIDTH iterations, then go to COMMIT.
  - COMMIT: copy BCD into the display register, copy the accumulator to `overflow`, return to IDLE.
- Dropping the top of the BCD register yields `number mod 10^DIGITS` by construction. No divider is used.
- `load` is ignored while `busy`=1; there is no queueing.
- The display register keeps the previous value until COMMIT, so the display never shows partial results.
- Scanner:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At terminal count, the prescaler returns to 0 and the digit index advances, wrapping from DIGITS-1 to 0.
- Segment codes (active-low cathode[6:0] with DP off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - Any nibble > 9 (not reachable) gives FF.
- `cathode[7]` = ~dp[index].

## Timing
- Reset values:
  - `anode`=8'hFF, `cathode`=8'hFF, `busy`=0, `overflow`=0.
  - Display register 0, prescaler 0, index 0, FSM in IDLE.
- After reset release, the first digit is driven on the first clock edge.
- `load` accepted at edge 0:
  - `busy`=1 from edge 0 through edge WIDTH.
  - COMMIT occurs at edge WIDTH+1; `busy`=0 after it.
  - Total latency is WIDTH+2 cycles to display update.
- A new `load` may be accepted on the cycle `busy` reads 0.
- `anode`/`cathode` are registered and update on the same edge as the index change. They always reflect the same digit; no ghosting cycle is allowed.
- `reset_n` asserted mid-conversion aborts the conversion. Display and `overflow` return to reset values immediately, asynchronously.
- `load` coinciding with COMMIT is ignored.
- A `dp` change takes effect on the next clock edge.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN` defined:
  - Digits above the most-significant non-zero digit are blanked: `anode`=8'hFF and `cathode`=8'hFF for that digit's slot.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Scan timing is unchanged; a blanked slot is still a dark REFRESH_DIV period.
- Undefined: all DIGITS digits are always driven, including leading zeros.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles → `anode`=FF, `cathode`=FF, `busy`=0, `overflow`=0; release → anode=FE, cathode=C0.
- Conversion (DIGITS=8, WIDTH=27, REFRESH_DIV=4): load 1234 → `busy` high exactly 28 cycles. Scan then shows:
  - FE/99, FD/B0, FB/A4, F7/F9.
  - Digits 4-7 show C0 without the macro, or anode FF with the macro.
- Overflow (DIGITS=2, WIDTH=8): load 123 → digits show 3 (B0) and 2 (A4), `overflow`=1. Then load 99 → `overflow`=0.
- Busy rejection: load 5, then load 7 on the next cycle → display shows 5 (92); the second load has no effect.
- Reset mid-conversion: load 99999999, assert `reset_n` at cycle 10 → outputs at reset values, `busy`=0. A fresh load 0 afterwards shows C0 on digit 0.
- Scan/DP (DIGITS=3, REFRESH_DIV=4, dp=3'b010): anode sequence FE, FD, FB, FE changes every 4 cycles. `cathode[7]`=0 only while anode=FD.

Source files
------------

// File: rtl/seg_display_scan_if.sv
// Bus between counter/score logic and the seven-segment scan driver.
// The master drives the value, load strobe and decimal points; the slave returns status and pin drive.
interface seg_display_scan_if #(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned WIDTH  = 27
);
   logic [WIDTH-1:0]  number;
   logic              load;
   logic [DIGITS-1:0] dp;
   logic              busy;
   logic              overflow;
   logic [7:0]        cathode;
   logic [7:0]        anode;

   modport master (
      output number, load, dp,
      input  busy, overflow, cathode, anode
   );

   modport slave (
      input  number, load, dp,
      output busy, overflow, cathode, anode
   );
endinterface

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment driver: binary capture, shift-and-add-3 BCD conversion, digit scan.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank digits above the most-significant non-zero one.
module seg_display_scan #(
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned WIDTH       = 27,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              reset_n,
   seg_display_scan_if.slave bus
);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BCD_W-1:0] disp_q, disp_d;
   logic [BCD_W-1:0] bcd_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       anode_q, anode_d;
   logic [7:0]       cathode_q, cathode_d;
   logic [3:0]       digit;
   logic             dp_bit;
`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [IDX_W-1:0] msd;
`endif

   // Active-low G..A pattern for one BCD digit; codes above 9 go dark.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Add-3 correction applied to every nibble ahead of the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM next state; the bit leaving the top nibble marks a value beyond DIGITS digits.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      busy_d  = busy_q;
      ovf_d   = ovf_q;
      disp_d  = disp_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load) begin
               state_d = ST_SHIFT;
               bin_d   = bus.number;
               bcd_d   = '0;
               acc_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            acc_d          = acc_q | bcd_adj[BCD_W-1];
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            disp_d  = bcd_q;
            ovf_d   = acc_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Scanner: index and pin drive are computed together so anode and cathode never disagree.
   always_comb begin
      pre_d  = pre_q + PRE_W'(1);
      idx_d  = idx_q;
      if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      digit   = 4'd0;
      dp_bit  = 1'b0;
      anode_d = 8'hFF;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_d == IDX_W'(i)) begin
            digit      = disp_q[4*i +: 4];
            dp_bit     = bus.dp[i];
            anode_d[i] = 1'b0;
         end
      end
      cathode_d = {~dp_bit, seg7(digit)};
`ifdef SEG_LEADING_ZERO_BLANK_EN
      msd = '0;
      for (int i = 1; i < int'(DIGITS); i++) begin
         if (disp_q[4*i +: 4] != 4'd0) begin
            msd = IDX_W'(i);
         end
      end
      if (idx_d > msd) begin
         anode_d   = 8'hFF;
         cathode_d = 8'hFF;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         disp_q    <= '0;
         cnt_q     <= '0;
         acc_q     <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         pre_q     <= '0;
         idx_q     <= '0;
         anode_q   <= 8'hFF;
         cathode_q <= 8'hFF;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         disp_q    <= disp_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;
   assign bus.anode    = anode_q;
   assign bus.cathode  = cathode_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: three instances (8/27, 2/8, 3/10 digits/width) checked against
// a decimal-arithmetic display model; obeys SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_display_scan;
   localparam int unsigned R = 4;

   logic       clk;
   logic       reset_n;
   int         checks = 0;
   int         errors = 0;
   int         cyc;
   longint     val [3];
   logic [7:0] dpv [3];
   logic [7:0] seg_tab [10];

   seg_display_scan_if #(.DIGITS(8), .WIDTH(27)) ifa ();
   seg_display_scan_if #(.DIGITS(2), .WIDTH(8))  ifb ();
   seg_display_scan_if #(.DIGITS(3), .WIDTH(10)) ifc ();

   seg_display_scan #(.DIGITS(8), .WIDTH(27), .REFRESH_DIV(R)) u_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
   seg_display_scan #(.DIGITS(2), .WIDTH(8),  .REFRESH_DIV(R)) u_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));
   seg_display_scan #(.DIGITS(3), .WIDTH(10), .REFRESH_DIV(R)) u_c (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; digit slot k/R mod DIGITS is lit after edge k.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic int digits_of(input int inst);
      return (inst == 0) ? 8 : (inst == 1) ? 2 : 3;
   endfunction

   function automatic int width_of(input int inst);
      return (inst == 0) ? 27 : (inst == 1) ? 8 : 10;
   endfunction

   function automatic logic blanked(input int d, input longint v, input int i);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      return (i > 0) && ((v % pow10(d)) < pow10(i));
`else
      return 1'b0 && (d > 0) && (v >= 0) && (i >= 0);
`endif
   endfunction

   function automatic logic [7:0] exp_anode(input int d, input longint v, input int i);
      logic [7:0] a;
      a = 8'h01 << i;
      a = ~a;
      if (blanked(d, v, i)) a = 8'hFF;
      return a;
   endfunction

   function automatic logic [7:0] exp_cathode(input int d, input longint v, input logic [7:0] dpm, input int i);
      logic [7:0] c;
      int         dig;
      dig  = int'(((v % pow10(d)) / pow10(i)) % 10);
      c    = seg_tab[dig];
      c[7] = ~dpm[i];
      if (blanked(d, v, i)) c = 8'hFF;
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int inst, output logic [7:0] an, output logic [7:0] ca,
                         output logic b, output logic o);
      case (inst)
         0:       begin an = ifa.anode; ca = ifa.cathode; b = ifa.busy; o = ifa.overflow; end
         1:       begin an = ifb.anode; ca = ifb.cathode; b = ifb.busy; o = ifb.overflow; end
         default: begin an = ifc.anode; ca = ifc.cathode; b = ifc.busy; o = ifc.overflow; end
      endcase
   endtask

   task automatic drive(input int inst, input longint v, input logic ld);
      case (inst)
         0:       begin ifa.number = 27'(v); ifa.load = ld; end
         1:       begin ifb.number = 8'(v);  ifb.load = ld; end
         default: begin ifc.number = 10'(v); ifc.load = ld; end
      endcase
   endtask

   task automatic set_dp(input int inst, input logic [7:0] x);
      case (inst)
         0:       ifa.dp = x;
         1:       ifb.dp = 2'(x);
         default: ifc.dp = 3'(x);
      endcase
      dpv[inst] = x;
   endtask

   task automatic scan_cmp(input int inst, input string tag);
      logic [7:0] an, ca;
      logic       b, o;
      int         d, i;
      d = digits_of(inst);
      i = (cyc / int'(R)) % d;
      sample(inst, an, ca, b, o);
      chk({tag, "_anode"},   32'(an), 32'(exp_anode(d, val[inst], i)));
      chk({tag, "_cathode"}, 32'(ca), 32'(exp_cathode(d, val[inst], dpv[inst], i)));
   endtask

   task automatic check_scan(input int inst, input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         tick();
         scan_cmp(inst, tag);
      end
   endtask

   // Load v; with hold, keep load high carrying v2 until busy drops. Display must hold old value meanwhile.
   task automatic load_conv(input int inst, input longint v, input longint v2, input logic hold,
                            input string tag);
      logic [7:0] an, ca;
      logic       b, o;
      int         bcnt;
      drive(inst, v, 1'b1);
      bcnt = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (k == 0) drive(inst, v2, hold);
         scan_cmp(inst, {tag, "_hold"});
         sample(inst, an, ca, b, o);
         if (b !== 1'b1) break;
         bcnt++;
      end
      drive(inst, v2, 1'b0);
      chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(width_of(inst) + 1));
      chk({tag, "_overflow"}, 32'(o), 32'(v >= pow10(digits_of(inst))));
      val[inst] = v;
   endtask

   initial begin
      logic [7:0] an, ca;
      logic       b, o;
      longint     v;

      seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(k, 0, 1'b0);
         set_dp(k, 8'h00);
         val[k] = 0;
      end

      // Reset values
      repeat (5) tick();
      sample(0, an, ca, b, o);
      chk("rst_anode", 32'(an), 32'h0FF);
      chk("rst_cathode", 32'(ca), 32'h0FF);
      chk("rst_busy", 32'(b), 32'h0);
      chk("rst_overflow", 32'(o), 32'h0);
      sample(1, an, ca, b, o);
      chk("rst_anode_b", 32'(an), 32'h0FF);
      sample(2, an, ca, b, o);
      chk("rst_cathode_c", 32'(ca), 32'h0FF);

      reset_n = 1'b1;
      tick();
      sample(0, an, ca, b, o);
      chk("first_anode", 32'(an), 32'h0FE);
      chk("first_cathode", 32'(ca), 32'h0C0);
      check_scan(0, 34, "idle_a");

      // 1234 on the 8-digit instance
      load_conv(0, 1234, 1234, 1'b0, "ld1234");
      check_scan(0, 40, "scan1234");

      // Overflow on the 2-digit instance
      load_conv(1, 123, 123, 1'b0, "ovf123");
      check_scan(1, 12, "scan123");
      load_conv(1, 99, 99, 1'b0, "ovf99");
      check_scan(1, 12, "scan99");

      // Second load while busy (and through COMMIT) is dropped
      load_conv(0, 5, 7, 1'b1, "rej");
      tick();
      sample(0, an, ca, b, o);
      chk("rej_commit_busy", 32'(b), 32'h0);
      scan_cmp(0, "rej_post");
      check_scan(0, 34, "rej_scan");

      // Scan sequence and decimal points on the 3-digit instance
      set_dp(2, 8'h02);
      load_conv(2, longint'($urandom_range(100, 999)), 0, 1'b0, "dp_c");
      check_scan(2, 26, "dp_c_scan");
      set_dp(2, 8'h05);
      check_scan(2, 14, "dp_c_chg");

      // Randomised values and decimal points
      for (int t = 0; t < 6; t++) begin
         v = (t % 2 == 1) ? longint'($urandom_range(99999999, 134217727))
                          : longint'($urandom_range(0, 99999999));
         set_dp(0, 8'($urandom_range(0, 255)));
         load_conv(0, v, v, 1'b0, "rnd_a");
         check_scan(0, 34, "rnd_a_scan");
         set_dp(1, 8'($urandom_range(0, 3)));
         load_conv(1, longint'($urandom_range(0, 255)), 0, 1'b0, "rnd_b");
         check_scan(1, 10, "rnd_b_scan");
      end

      // Reset mid-conversion
      set_dp(0, 8'h00);
      drive(0, 99999999, 1'b1);
      tick();
      drive(0, 99999999, 1'b0);
      repeat (9) tick();
      reset_n = 1'b0;
      #1;
      sample(0, an, ca, b, o);
      chk("midrst_anode", 32'(an), 32'h0FF);
      chk("midrst_cathode", 32'(ca), 32'h0FF);
      chk("midrst_busy", 32'(b), 32'h0);
      chk("midrst_overflow", 32'(o), 32'h0);
      sample(1, an, ca, b, o);
      chk("midrst_overflow_b", 32'(o), 32'h0);
      for (int k = 0; k < 3; k++) val[k] = 0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      scan_cmp(0, "postrst");
      load_conv(0, 0, 0, 1'b0, "ld0");
      check_scan(0, 34, "scan0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
